// File: rtl/seq_pattern_gen_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM encoding and the default test pattern.
// The PAR state exists only when SEQ_GEN_PARITY_EN is defined.
package seq_pattern_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
`ifdef SEQ_GEN_PARITY_EN
        ST_PAR   = 2'd2,
`endif
        ST_GAP   = 2'd3
    } seq_state_e;

    localparam logic [3:0] SEQ_PATTERN = 4'b1011;

endpackage

// File: rtl/seq_pattern_gen_shift_reg.sv
// Pattern shift register: parallel load, shift-left, MSB tap. Load wins over shift.
module seq_pattern_gen_shift_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] load_val_i,
    output logic         msb_o
);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (load_i) begin
            sr_d = load_val_i;
        end else if (shift_i) begin
            sr_d = {sr_q[W-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign msb_o = sr_q[W-1];

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured pattern MSB-first, repeated with idle gaps.
// Define SEQ_GEN_PARITY_EN to append an even-parity bit to every copy.
module seq_pattern_gen
    import seq_pattern_gen_pkg::*;
#(
    parameter int PATTERN_W = 4,
    parameter int CNT_W     = 4,
    parameter int GAP_W     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [CNT_W-1:0]     repeat_cnt,
    input  logic [GAP_W-1:0]     gap_len,
    output logic                 data_out,
    output logic                 out_valid,
    output logic                 busy,
    output logic                 done
);

    localparam int BIT_W = $clog2(PATTERN_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PATTERN_W - 1);

    seq_state_e           state_q, state_d;
    logic [PATTERN_W-1:0] pat_q, pat_d;
    logic [CNT_W-1:0]     rep_q, rep_d;
    logic [GAP_W-1:0]     gap_len_q, gap_len_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 done_q, done_d;

    logic                 sr_load, sr_shift, sr_msb;
    logic [PATTERN_W-1:0] sr_load_val;
    logic                 last_bit, copy_end, more_copies;
    seq_state_e           end_state;

    assign last_bit    = (state_q == ST_SHIFT) && (bit_cnt_q == LAST_BIT);
    assign more_copies = (rep_q > CNT_W'(1));
`ifdef SEQ_GEN_PARITY_EN
    assign copy_end    = (state_q == ST_PAR);
`else
    assign copy_end    = last_bit;
`endif

    // A gap of zero skips GAP entirely so the next MSB follows the last bit directly.
    assign end_state = !more_copies          ? ST_IDLE :
                       (gap_len_q != '0)     ? ST_GAP  : ST_SHIFT;

    seq_pattern_gen_shift_reg #(.W(PATTERN_W)) u_shift_reg (
        .clk       (clock),
        .rst_n     (reset),
        .load_i    (sr_load),
        .shift_i   (sr_shift),
        .load_val_i(sr_load_val),
        .msb_o     (sr_msb)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_SHIFT;
            ST_SHIFT: begin
                if (last_bit) begin
`ifdef SEQ_GEN_PARITY_EN
                    state_d = ST_PAR;
`else
                    state_d = end_state;
`endif
                end
            end
`ifdef SEQ_GEN_PARITY_EN
            ST_PAR:   state_d = end_state;
`endif
            ST_GAP:   if (gap_cnt_q == GAP_W'(1)) state_d = ST_SHIFT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pat_d       = pat_q;
        rep_d       = rep_q;
        gap_len_d   = gap_len_q;
        gap_cnt_d   = gap_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        sr_load     = 1'b0;
        sr_shift    = 1'b0;
        sr_load_val = pat_q;
        done_d      = (state_q != ST_IDLE) && (state_d == ST_IDLE);

        if (state_q == ST_IDLE && start) begin
            pat_d       = pattern;
            rep_d       = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
            gap_len_d   = gap_len;
            bit_cnt_d   = '0;
            sr_load     = 1'b1;
            sr_load_val = pattern;
        end

        if (state_q == ST_SHIFT) begin
            if (last_bit) begin
                bit_cnt_d = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                sr_shift  = 1'b1;
            end
        end

        // Reload from the captured copy so later input changes never leak in.
        if (copy_end && more_copies) begin
            rep_d = rep_q - CNT_W'(1);
            if (gap_len_q != '0) begin
                gap_cnt_d = gap_len_q;
            end else begin
                sr_load = 1'b1;
            end
        end

        if (state_q == ST_GAP) begin
            if (gap_cnt_q == GAP_W'(1)) begin
                gap_cnt_d = '0;
                sr_load   = 1'b1;
            end else begin
                gap_cnt_d = gap_cnt_q - GAP_W'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pat_q     <= '0;
            rep_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            bit_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            rep_q     <= rep_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        data_out  = 1'b0;
        out_valid = 1'b0;
        busy      = (state_q != ST_IDLE);
        done      = done_q;
        case (state_q)
            ST_SHIFT: begin
                out_valid = 1'b1;
                data_out  = sr_msb;
            end
`ifdef SEQ_GEN_PARITY_EN
            ST_PAR: begin
                out_valid = 1'b1;
                data_out  = ^pat_q;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Directed bench for seq_pattern_gen: cycle-by-cycle vectors of valid/data/busy/done per transfer.
// The parity scenario runs only when SEQ_GEN_PARITY_EN is defined.
module tb_seq_pattern_gen;
    import seq_pattern_gen_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] repeat_cnt;
    logic [3:0] gap_len;
    logic       data_out, out_valid, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    seq_pattern_gen #(.PATTERN_W(4), .CNT_W(4), .GAP_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .repeat_cnt(repeat_cnt),
        .gap_len   (gap_len),
        .data_out  (data_out),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Vectors hold cycle 1 in bit n-1 down to cycle n in bit 0.
    task automatic run_vec(input string name, input logic [3:0] pat, input logic [3:0] rep,
                           input logic [3:0] gap, input int n,
                           input logic [31:0] v_exp, input logic [31:0] d_exp,
                           input logic [31:0] b_exp, input logic [31:0] dn_exp,
                           input int pulse_c, input logic [3:0] p_pat,
                           input logic [3:0] p_rep, input logic [3:0] p_gap);
        int bad0;
        bad0       = n_bad;
        pattern    = pat;
        repeat_cnt = rep;
        gap_len    = gap;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        pattern    = ~pat;
        repeat_cnt = 4'd5;
        gap_len    = 4'd3;
        for (int c = 1; c <= n; c++) begin
            if (c == pulse_c) begin
                start      = 1'b1;
                pattern    = p_pat;
                repeat_cnt = p_rep;
                gap_len    = p_gap;
            end
            check_eq($sformatf("%s c%0d out_valid", name, c), 32'(out_valid), 32'(v_exp[n-c]));
            check_eq($sformatf("%s c%0d data_out", name, c), 32'(data_out), 32'(d_exp[n-c]));
            check_eq($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(b_exp[n-c]));
            check_eq($sformatf("%s c%0d done", name, c), 32'(done), 32'(dn_exp[n-c]));
            tick();
            start = 1'b0;
        end
        $display("%s: pattern=%b repeat=%0d gap=%0d cycles=%0d errors=%0d",
                 name, pat, rep, gap, n, n_bad - bad0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        pattern    = 4'b0000;
        repeat_cnt = 4'd0;
        gap_len    = 4'd0;
        #2;
        check_eq("reset data_out", 32'(data_out), 32'd0);
        check_eq("reset out_valid", 32'(out_valid), 32'd0);
        check_eq("reset busy", 32'(busy), 32'd0);
        check_eq("reset done", 32'(done), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_eq("post-reset busy", 32'(busy), 32'd0);
        check_eq("post-reset done", 32'(done), 32'd0);

        run_vec("T1", SEQ_PATTERN, 4'd1, 4'd0, 5,
                32'b11110, 32'b10110, 32'b11110, 32'b00001, 0, 4'd0, 4'd0, 4'd0);
        run_vec("T2", SEQ_PATTERN, 4'd3, 4'd0, 13,
                32'b1111111111110, 32'b1011101110110, 32'b1111111111110, 32'b0000000000001,
                0, 4'd0, 4'd0, 4'd0);
        run_vec("T3", SEQ_PATTERN, 4'd2, 4'd2, 11,
                32'b11110011110, 32'b10110010110, 32'b11111111110, 32'b00000000001,
                0, 4'd0, 4'd0, 4'd0);
        run_vec("T4", SEQ_PATTERN, 4'd0, 4'd0, 7,
                32'b1111000, 32'b1011000, 32'b1111000, 32'b0000100, 2, 4'b0101, 4'd3, 4'd0);
        run_vec("T7", 4'b0110, 4'd1, 4'd0, 10,
                32'b1111011110, 32'b0110011000, 32'b1111011110, 32'b0000100001,
                5, 4'b1100, 4'd1, 4'd0);

        // Asynchronous reset in the middle of a burst.
        pattern    = SEQ_PATTERN;
        repeat_cnt = 4'd2;
        gap_len    = 4'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        check_eq("T5 c1 out_valid", 32'(out_valid), 32'd1);
        check_eq("T5 c1 data_out", 32'(data_out), 32'd1);
        tick();
        check_eq("T5 c2 data_out", 32'(data_out), 32'd0);
        check_eq("T5 c2 busy", 32'(busy), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check_eq("T5 async data_out", 32'(data_out), 32'd0);
        check_eq("T5 async out_valid", 32'(out_valid), 32'd0);
        check_eq("T5 async busy", 32'(busy), 32'd0);
        check_eq("T5 async done", 32'(done), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            check_eq($sformatf("T5 held%0d busy", i), 32'(busy), 32'd0);
            check_eq($sformatf("T5 held%0d done", i), 32'(done), 32'd0);
        end
        reset = 1'b1;
        tick();
        check_eq("T5 release busy", 32'(busy), 32'd0);
        check_eq("T5 release done", 32'(done), 32'd0);
        $display("T5: reset mid-burst, outputs cleared");
        run_vec("T5b", SEQ_PATTERN, 4'd1, 4'd0, 5,
                32'b11110, 32'b10110, 32'b11110, 32'b00001, 0, 4'd0, 4'd0, 4'd0);

`ifdef SEQ_GEN_PARITY_EN
        run_vec("T6", SEQ_PATTERN, 4'd2, 4'd1, 12,
                32'b111110111110, 32'b101110101110, 32'b111111111110, 32'b000000000001,
                0, 4'd0, 4'd0, 4'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
